// File: rtl/multicycle_acc_controller.sv
// Multi-cycle FETCH/EXEC controller for the accumulator CPU; drives datapath strobes and retires instructions.
// Optional memory-wait timeout enabled by defining MEM_TIMEOUT_EN.
module multicycle_acc_controller #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] ac,
    input  logic              mem_ready,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic              addr_sel,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              pc_src,
    output logic              ac_src,
    output logic              ld_ac,
    output logic              ld_imm,
    output logic              alu_add,
    output logic              alu_sub,
    output logic              halted,
    output logic              bus_err,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [2:0] OP_LDA = 3'd0;
    localparam logic [2:0] OP_STA = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_JMP = 3'd4;
    localparam logic [2:0] OP_JEZ = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    state_t             state_q, state_d;
    logic               halted_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pending_c;
    logic               retire_c;
    logic               timeout_c;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC);
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               bus_err_q;
`endif

    // Next-state and strobe decode
    always_comb begin
        state_d   = state_q;
        rd_mem    = 1'b0;
        wr_mem    = 1'b0;
        addr_sel  = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_src    = 1'b0;
        ac_src    = 1'b0;
        ld_ac     = 1'b0;
        ld_imm    = 1'b0;
        alu_add   = 1'b0;
        alu_sub   = 1'b0;
        pending_c = 1'b0;
        retire_c  = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = FETCH;
            FETCH: begin
                rd_mem    = 1'b1;
                addr_sel  = 1'b1;
                pending_c = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        rd_mem    = 1'b1;
                        pending_c = 1'b1;
                        ac_src    = (opcode == OP_LDA);
                        alu_add   = (opcode == OP_ADD);
                        alu_sub   = (opcode == OP_SUB);
                        if (mem_ready) begin
                            ld_ac   = 1'b1;
                            state_d = FETCH;
                        end
                    end
                    OP_STA: begin
                        wr_mem    = 1'b1;
                        pending_c = 1'b1;
                        if (mem_ready) state_d = FETCH;
                    end
                    OP_JMP: begin
                        pc_src  = 1'b1;
                        state_d = FETCH;
                    end
                    OP_JEZ: begin
                        pc_src  = (ac == '0);
                        state_d = FETCH;
                    end
                    OP_LDI: begin
                        ld_imm  = 1'b1;
                        ld_ac   = 1'b1;
                        state_d = FETCH;
                    end
                    OP_HLT: state_d = HALT;
                endcase
                retire_c = (state_d != EXEC);
            end
            HALT: if (start) state_d = FETCH;
        endcase
`ifdef MEM_TIMEOUT_EN
        // Abort on the wait cycle that brings the counter to TIMEOUT_CYC
        if (pending_c && !mem_ready && (wait_q == WAIT_W'(TIMEOUT_CYC - 1))) begin
            timeout_c = 1'b1;
            retire_c  = 1'b0;
            state_d   = HALT;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            halted_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == IDLE) || (state_d == HALT);
            if (retire_c) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_comb begin
        wait_d = wait_q + WAIT_W'(1);
        if (!pending_c || mem_ready || (state_d != state_q)) wait_d = '0;
    end

    // Sticky until a start leaves IDLE/HALT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
            if (timeout_c)
                bus_err_q <= 1'b1;
            else if (start && ((state_q == IDLE) || (state_q == HALT)))
                bus_err_q <= 1'b0;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_timeout_c;
    assign unused_timeout_c = ^{32'(TIMEOUT_CYC), pending_c, timeout_c};
    assign bus_err = 1'b0;
`endif

    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_acc_controller.sv
// Scoreboard bench for multicycle_acc_controller: a per-instruction reference model queues expected
// cycle outputs; a negedge monitor pops and compares.
module tb_multicycle_acc_controller;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned TIMEOUT_CYC = 4;

    localparam logic [10:0] S_RD   = 11'b100_0000_0000;
    localparam logic [10:0] S_WR   = 11'b010_0000_0000;
    localparam logic [10:0] S_AS   = 11'b001_0000_0000;
    localparam logic [10:0] S_IRL  = 11'b000_1000_0000;
    localparam logic [10:0] S_PCI  = 11'b000_0100_0000;
    localparam logic [10:0] S_PCS  = 11'b000_0010_0000;
    localparam logic [10:0] S_ACS  = 11'b000_0001_0000;
    localparam logic [10:0] S_LDAC = 11'b000_0000_1000;
    localparam logic [10:0] S_LDI  = 11'b000_0000_0100;
    localparam logic [10:0] S_ADD  = 11'b000_0000_0010;
    localparam logic [10:0] S_SUB  = 11'b000_0000_0001;

    logic              clk;
    logic              rst;
    logic              start;
    logic [2:0]        opcode;
    logic [DATA_W-1:0] ac;
    logic              mem_ready;
    logic rd_mem, wr_mem, addr_sel, ir_load, pc_inc, pc_src, ac_src, ld_ac, ld_imm, alu_add, alu_sub;
    logic              halted, bus_err;
    logic [CNT_W-1:0]  instr_count;

    multicycle_acc_controller #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .ac(ac), .mem_ready(mem_ready),
        .rd_mem(rd_mem), .wr_mem(wr_mem), .addr_sel(addr_sel), .ir_load(ir_load), .pc_inc(pc_inc),
        .pc_src(pc_src), .ac_src(ac_src), .ld_ac(ld_ac), .ld_imm(ld_imm), .alu_add(alu_add),
        .alu_sub(alu_sub), .halted(halted), .bus_err(bus_err), .instr_count(instr_count)
    );

    typedef struct packed {
        logic [10:0]      strobes;
        logic             halted;
        logic             bus_err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             expq[$];
    int               vectors = 0;
    int               miscompares = 0;
    logic [CNT_W-1:0] m_cnt;
    logic             m_halted;
    logic             m_bus_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] dut_strobes();
        return {rd_mem, wr_mem, addr_sel, ir_load, pc_inc, pc_src, ac_src, ld_ac, ld_imm, alu_add, alu_sub};
    endfunction

    function automatic logic rs();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] rop();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic logic [DATA_W-1:0] rac();
        logic [DATA_W-1:0] one;
        one = DATA_W'(1);
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return one << $urandom_range(0, DATA_W - 1);
            default: return DATA_W'($urandom);
        endcase
    endfunction

    // Monitor: one expected entry per driven cycle, sampled mid-cycle
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                a = {dut_strobes(), halted, bus_err, instr_count};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t: got strobes=%b halted=%b bus_err=%b count=%0d, want strobes=%b halted=%b bus_err=%b count=%0d",
                             $time, a.strobes, a.halted, a.bus_err, a.cnt, e.strobes, e.halted, e.bus_err, e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [2:0] op, input logic [DATA_W-1:0] a,
                       input logic mr, input logic [10:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; start = s; opcode = op; ac = a; mem_ready = mr;
        e.strobes = st;
        e.halted  = m_halted;
        e.bus_err = m_bus_err;
        e.cnt     = m_cnt;
        expq.push_back(e);
    endtask

    task automatic fetch(input int fw);
        for (int i = 0; i < fw; i++) cyc(1'b0, rs(), rop(), rac(), 1'b0, S_RD | S_AS);
        cyc(1'b0, rs(), rop(), rac(), 1'b1, S_RD | S_AS | S_IRL | S_PCI);
    endtask

    // One full instruction: fetch with fw waits, execute with ew waits (memory ops only)
    task automatic instr(input logic [2:0] op, input int fw, input int ew, input logic [DATA_W-1:0] a);
        logic [10:0] base, done;
        fetch(fw);
        base = '0;
        done = '0;
        case (op)
            3'd0: begin base = S_RD | S_ACS; done = base | S_LDAC; end
            3'd1: begin base = S_WR;         done = S_WR;          end
            3'd2: begin base = S_RD | S_ADD; done = base | S_LDAC; end
            3'd3: begin base = S_RD | S_SUB; done = base | S_LDAC; end
            3'd4: done = S_PCS;
            3'd5: done = (a == '0) ? S_PCS : 11'b0;
            3'd6: done = S_LDI | S_LDAC;
            default: done = '0;
        endcase
        if (op <= 3'd3) begin
            for (int i = 0; i < ew; i++) cyc(1'b0, rs(), op, a, 1'b0, base);
            cyc(1'b0, rs(), op, a, 1'b1, done);
        end else begin
            cyc(1'b0, rs(), op, a, rs(), done);
        end
        m_cnt = m_cnt + CNT_W'(1);
        if (op == 3'd7) m_halted = 1'b1;
    endtask

    task automatic halt_resume(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rop(), rac(), rs(), 11'b0);
        cyc(1'b0, 1'b1, rop(), rac(), rs(), 11'b0);
        m_halted  = 1'b0;
        m_bus_err = 1'b0;
    endtask

    initial begin
        logic [2:0] op;
        rst = 1'b1; start = 1'b0; opcode = '0; ac = '0; mem_ready = 1'b0;
        m_cnt = '0; m_halted = 1'b1; m_bus_err = 1'b0;

        repeat (2) cyc(1'b1, 1'b1, rop(), rac(), 1'b1, 11'b0);
        repeat (2) cyc(1'b0, 1'b0, rop(), rac(), 1'b1, 11'b0);
        cyc(1'b0, 1'b1, rop(), rac(), 1'b0, 11'b0);
        m_halted = 1'b0;

        instr(3'd6, 0, 0, rac());
        instr(3'd2, 0, 0, rac());
        instr(3'd0, 0, 3, rac());
        instr(3'd5, 0, 0, 16'h0000);
        instr(3'd5, 1, 0, 16'h8000);
        instr(3'd5, 0, 0, 16'h0001);
        instr(3'd1, 2, 2, rac());
        instr(3'd3, 1, 1, rac());
        instr(3'd4, 0, 0, rac());
        instr(3'd7, 0, 0, rac());
        halt_resume(3);

        for (int k = 0; k < 60; k++) begin
            op = rop();
            instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rac());
            if (op == 3'd7) halt_resume($urandom_range(0, 3));
        end

`ifdef MEM_TIMEOUT_EN
        repeat (TIMEOUT_CYC) cyc(1'b0, 1'b0, rop(), rac(), 1'b0, S_RD | S_AS);
        m_halted  = 1'b1;
        m_bus_err = 1'b1;
        cyc(1'b0, 1'b0, rop(), rac(), 1'b1, 11'b0);
        halt_resume(1);
        instr(3'd6, 0, 0, rac());
`else
        instr(3'd6, 20, 0, rac());
`endif

        // Asynchronous reset in the middle of a pending store
        fetch(0);
        cyc(1'b0, 1'b0, 3'd1, rac(), 1'b0, S_WR);
        @(negedge clk);
        #2;
        chk("wr_mem_before_rst", 32'(wr_mem), 32'd1);
        rst = 1'b1;
        #1;
        chk("wr_mem_async_drop", 32'(wr_mem), 32'd0);
        chk("halted_async", 32'(halted), 32'd1);
        chk("count_async", 32'(instr_count), 32'd0);
        m_cnt = '0; m_halted = 1'b1; m_bus_err = 1'b0;
        cyc(1'b1, 1'b0, 3'd1, rac(), 1'b0, 11'b0);
        cyc(1'b0, 1'b0, rop(), rac(), 1'b1, 11'b0);
        cyc(1'b0, 1'b1, rop(), rac(), 1'b0, 11'b0);
        m_halted = 1'b0;
        instr(3'd6, 0, 0, rac());
        instr(3'd7, 1, 0, rac());
        cyc(1'b0, 1'b0, rop(), rac(), 1'b1, 11'b0);

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_acc_controller.md
Name: multicycle_acc_controller

Overview:
- Parametrised multi-cycle control unit for the accumulator CPU; the next generation of the single-cycle controller.
- Sequences FETCH/EXEC through a registered state machine, waits on a memory ready handshake and owns the run/halt state.
- Counts retired instructions and drives all datapath strobes: memory, accumulator, ALU and PC.
- Instantiated beside the datapath; PC, IR and AC registers stay in the datapath.

Parameters:
- DATA_W, 16, accumulator width used for the JEZ zero test.
- CNT_W, 16, width of the retired-instruction counter.
- TIMEOUT_CYC, 64, memory-wait limit in cycles; used only with MEM_TIMEOUT_EN; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  leave IDLE/HALT and begin fetching; ignored while running.
- opcode  in  3  IR opcode field, valid in EXEC.
- ac  in  DATA_W  accumulator value.
- mem_ready  in  1  memory completes the current read/write this cycle.
- rd_mem  out  1  memory read request.
- wr_mem  out  1  memory write request.
- addr_sel  out  1  1 = address from PC (fetch), 0 = address from IR operand.
- ir_load  out  1  capture fetched word into IR.
- pc_inc  out  1  PC <= PC+1.
- pc_src  out  1  PC <= IR operand.
- ac_src  out  1  AC input mux selects memory data.
- ld_ac  out  1  AC write enable.
- ld_imm  out  1  AC input mux selects sign-extended immediate.
- alu_add  out  1  ALU add.
- alu_sub  out  1  ALU subtract.
- halted  out  1  registered; 1 in IDLE or HALT.
- bus_err  out  1  registered sticky memory-timeout flag.
- instr_count  out  CNT_W  registered retired-instruction count.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT.
- State, halted, bus_err and instr_count are registered. All strobes are combinational decodes of state, opcode, mem_ready and ac. Every strobe is 0 in any state or case not listed below.
- Reset (asynchronous, takes effect mid-operation): state=IDLE, halted=1, bus_err=0, instr_count=0, all strobes 0 immediately.
- IDLE: start=1 -> FETCH on the next edge; halted falls with that edge.
- FETCH:
  - rd_mem=1, addr_sel=1.
  - mem_ready=0: remain in FETCH.
  - mem_ready=1: ir_load=1 and pc_inc=1 in the same cycle; -> EXEC.
- EXEC by opcode:
  - 000 LDA: rd_mem=1, ac_src=1; ld_ac=1 only in the cycle mem_ready=1, then -> FETCH; otherwise remain in EXEC.
  - 001 STA: wr_mem=1 held until mem_ready=1, then -> FETCH.
  - 010 ADD / 011 SUB: rd_mem=1, alu_add or alu_sub=1; ld_ac=1 only when mem_ready=1, then -> FETCH.
  - 100 JMP: pc_src=1 for one cycle; -> FETCH.
  - 101 JEZ: pc_src=1 iff all DATA_W bits of ac are 0; -> FETCH.
  - 110 LDI: ld_imm=1, ld_ac=1 for one cycle; -> FETCH.
  - 111 HLT: no strobes; -> HALT.
- instr_count: increments by 1 on every EXEC exit, including HLT. Wraps modulo 2^CNT_W, no saturation.
- HALT:
  - halted=1, no memory requests.
  - start=1 -> FETCH (resumes at the current PC) and clears bus_err.
- mem_ready asserted outside a pending request (IDLE, HALT, or a non-memory EXEC) is ignored.
- Latency:
  - Minimum 2 cycles per instruction; JMP/JEZ/LDI/HLT take exactly 2.
  - Each memory wait cycle adds 1.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A wait counter counts consecutive cycles in which a request is pending (FETCH, or a memory EXEC) with mem_ready=0.
  - The counter clears when mem_ready=1 or on any state change.
  - When it reaches TIMEOUT_CYC, the next edge sets state=HALT and bus_err=1. The aborted instruction does not increment instr_count.
  - bus_err stays set until rst or start.
- MEM_TIMEOUT_EN not defined: no counter; waits are unbounded; bus_err is tied to 0.

Test Plan:
- Reset mid-EXEC of STA with wr_mem=1 -> wr_mem drops asynchronously; after release halted=1, instr_count=0, state IDLE.
- start pulse, then program LDI 5, ADD [x], mem_ready held high -> LDI takes 2 cycles with ld_imm=ld_ac=1; ADD asserts alu_add+ld_ac in its EXEC cycle; instr_count=2.
- LDA with mem_ready low for 3 cycles in EXEC -> rd_mem held 4 cycles; ld_ac pulses exactly once, in the 4th cycle.
- JEZ with ac=16'h0000 -> pc_src=1; JEZ with ac=16'h8000 -> pc_src=0; both return to FETCH after 1 EXEC cycle.
- HLT -> halted=1 two cycles after its fetch, no rd_mem while halted, instr_count incremented; start -> FETCH resumes.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=4, mem_ready held low in FETCH -> HALT entered after 4 wait cycles, bus_err=1; start clears bus_err. Without the macro, the controller stays in FETCH indefinitely and bus_err stays 0.
